// File: rtl/hsem_pkg.sv
// Shared definitions for the hsem_multi hardware semaphore: register map,
// field positions, size limits and the semaphore entry record.
package hsem_pkg;

    localparam int unsigned MAX_SEM    = 32;
    localparam int unsigned MAX_MASTER = 4;

    localparam logic [9:0] R_BASE    = 10'h000;
    localparam logic [9:0] RLR_BASE  = 10'h080;
    localparam logic [9:0] BANK_BASE = 10'h100;
    localparam logic [9:0] CR_OFF    = 10'h140;
    localparam logic [9:0] KEYR_OFF  = 10'h144;

    localparam int unsigned LOCK_BIT   = 31;
    localparam int unsigned COREID_LSB = 8;

    // Word slot inside a per-master bank
    localparam logic [1:0] BANK_IER  = 2'd0;
    localparam logic [1:0] BANK_ICR  = 2'd1;
    localparam logic [1:0] BANK_ISR  = 2'd2;
    localparam logic [1:0] BANK_MISR = 2'd3;

    typedef struct packed {
        logic       lock;
        logic [7:0] coreid;
        logic [7:0] procid;
    } sem_entry_t;

    function automatic logic [31:0] fmt_entry(input sem_entry_t e);
        logic [31:0] v;
        v                      = '0;
        v[LOCK_BIT]            = e.lock;
        v[COREID_LSB +: 8]     = e.coreid;
        v[7:0]                 = e.procid;
        return v;
    endfunction

endpackage

// File: rtl/hsem_ahb_if.sv
// AHB-Lite slave front end: captures the address phase and presents
// data-phase read/write strobes; always zero-wait, always OKAY.
module hsem_ahb_if
    import hsem_pkg::*;
#(
    parameter int MID_W = 4
) (
    input  logic             i_hclk,
    input  logic             i_hreset,
    input  logic             i_hsel,
    input  logic             i_hready,
    input  logic [1:0]       i_htrans,
    input  logic             i_hwrite,
    input  logic [31:0]      i_haddr,
    input  logic [MID_W-1:0] i_hmaster,
    output logic             o_hreadyout,
    output logic [1:0]       o_hresp,
    output logic [7:0]       o_addr,
    output logic [MID_W-1:0] o_master,
    output logic             o_wr,
    output logic             o_rd
);

    logic             r_valid;
    logic             r_write;
    logic [7:0]       r_addr;
    logic [MID_W-1:0] r_master;
    logic             w_start;
    logic             w_unused;

    assign w_start  = i_hsel & i_hready & i_htrans[1];
    assign w_unused = ^{i_haddr[31:10], i_haddr[1:0], i_htrans[0]};

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_valid  <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_master <= '0;
        end else begin
            r_valid <= w_start;
            if (w_start) begin
                r_write  <= i_hwrite;
                r_addr   <= i_haddr[9:2];
                r_master <= i_hmaster;
            end
        end
    end

    assign o_addr      = r_addr;
    assign o_master    = r_master;
    assign o_wr        = r_valid & r_write;
    assign o_rd        = r_valid & ~r_write;
    assign o_hreadyout = 1'b1;
    assign o_hresp     = 2'b00;

endmodule

// File: rtl/hsem_multi.sv
// Multi-master hardware semaphore with per-master release interrupts.
// Optional HSEM_READ_LOCK_EN turns RLR reads into one-step lock attempts.
module hsem_multi
    import hsem_pkg::*;
#(
    parameter int NUM_SEM    = 32,
    parameter int NUM_MASTER = 2,
    parameter int MID_W      = 4
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic                  hready,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [31:0]           haddr,
    input  logic [MID_W-1:0]      hmaster,
    input  logic [31:0]           hwdata,
    output logic                  hreadyout,
    output logic [1:0]            hresp,
    output logic [31:0]           hrdata,
    output logic [NUM_MASTER-1:0] intr
);

    logic [7:0]       w_addr;
    logic [MID_W-1:0] w_master;
    logic             w_wr;
    logic             w_rd;

    hsem_ahb_if #(.MID_W(MID_W)) u_ahb_if (
        .i_hclk      (hclk),
        .i_hreset    (hreset),
        .i_hsel      (hsel),
        .i_hready    (hready),
        .i_htrans    (htrans),
        .i_hwrite    (hwrite),
        .i_haddr     (haddr),
        .i_hmaster   (hmaster),
        .o_hreadyout (hreadyout),
        .o_hresp     (hresp),
        .o_addr      (w_addr),
        .o_master    (w_master),
        .o_wr        (w_wr),
        .o_rd        (w_rd)
    );

    logic [9:0]                    w_baddr;
    logic [$clog2(MAX_SEM)-1:0]    w_idx;
    logic [$clog2(MAX_MASTER)-1:0] w_bank;
    logic [1:0]                    w_breg;
    logic [7:0]                    w_coreid;
    logic                          w_is_r;
    logic                          w_is_bank;
    logic                          w_is_cr;
    logic                          w_is_keyr;
    logic                          w_key_ok;

    assign w_baddr   = {w_addr, 2'b00};
    assign w_idx     = w_baddr[6:2];
    assign w_bank    = w_baddr[5:4];
    assign w_breg    = w_baddr[3:2];
    assign w_coreid  = 8'(w_master);
    assign w_is_r    = (w_baddr[9:7] == R_BASE[9:7]);
    assign w_is_bank = (w_baddr[9:6] == BANK_BASE[9:6]);
    assign w_is_cr   = (w_baddr == CR_OFF);
    assign w_is_keyr = (w_baddr == KEYR_OFF);

    sem_entry_t          r_sem [NUM_SEM];
    logic [NUM_SEM-1:0]  r_ier [NUM_MASTER];
    logic [NUM_SEM-1:0]  r_isr [NUM_MASTER];
    logic [15:0]         r_keyr;

    sem_entry_t          w_sem_next [NUM_SEM];
    logic [NUM_SEM-1:0]  w_release;
    logic [NUM_SEM-1:0]  w_icr_clr [NUM_MASTER];
    logic [NUM_MASTER-1:0] w_ier_we;

    assign w_key_ok = (hwdata[31:16] == r_keyr);

`ifdef HSEM_READ_LOCK_EN
    logic       w_is_rlr;
    sem_entry_t w_rlr_entry;
    assign w_is_rlr    = (w_baddr[9:7] == RLR_BASE[9:7]);
    assign w_rlr_entry = '{lock: 1'b1, coreid: w_coreid, procid: 8'h00};
`endif

    // NOTE: every combinational output gets a default before any branch,
    // otherwise an unassigned path would infer a latch.
    always_comb begin
        w_release = '0;
        for (int i = 0; i < NUM_SEM; i++) begin
            w_sem_next[i] = r_sem[i];
            if (w_wr && w_is_r && int'(w_idx) == i) begin
                if (hwdata[LOCK_BIT]) begin
                    if (!r_sem[i].lock)
                        w_sem_next[i] = '{lock: 1'b1, coreid: w_coreid, procid: hwdata[7:0]};
                end else if (r_sem[i].lock && r_sem[i].coreid == w_coreid &&
                             r_sem[i].procid == hwdata[7:0]) begin
                    w_sem_next[i] = '0;
                    w_release[i]  = 1'b1;
                end
            end
            if (w_wr && w_is_cr && w_key_ok && r_sem[i].lock &&
                r_sem[i].coreid == hwdata[COREID_LSB +: 8]) begin
                w_sem_next[i] = '0;
                w_release[i]  = 1'b1;
            end
`ifdef HSEM_READ_LOCK_EN
            if (w_rd && w_is_rlr && int'(w_idx) == i && !r_sem[i].lock)
                w_sem_next[i] = w_rlr_entry;
`endif
        end
    end

    always_comb begin
        for (int m = 0; m < NUM_MASTER; m++) begin
            w_ier_we[m]  = w_wr && w_is_bank && int'(w_bank) == m && w_breg == BANK_IER;
            w_icr_clr[m] = (w_wr && w_is_bank && int'(w_bank) == m && w_breg == BANK_ICR)
                           ? hwdata[NUM_SEM-1:0] : '0;
        end
    end

    // NOTE: the semaphore array is reset element by element because every
    // lock must read free after reset; it is flops, not a RAM macro.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            for (int i = 0; i < NUM_SEM; i++)
                r_sem[i] <= '0;
            for (int m = 0; m < NUM_MASTER; m++) begin
                r_ier[m] <= '0;
                r_isr[m] <= '0;
            end
            r_keyr <= '0;
        end else begin
            r_sem <= w_sem_next;
            if (w_wr && w_is_keyr)
                r_keyr <= hwdata[31:16];
            for (int m = 0; m < NUM_MASTER; m++) begin
                if (w_ier_we[m])
                    r_ier[m] <= hwdata[NUM_SEM-1:0];
                // A release in the same cycle as an ICR write wins over the clear
                r_isr[m] <= (r_isr[m] & ~w_icr_clr[m]) | w_release;
            end
        end
    end

    always_comb begin
        for (int m = 0; m < NUM_MASTER; m++)
            intr[m] = |(r_isr[m] & r_ier[m]);
    end

    always_comb begin
        hrdata = '0;
        if (w_rd) begin
            for (int i = 0; i < NUM_SEM; i++) begin
                if (w_is_r && int'(w_idx) == i)
                    hrdata = fmt_entry(r_sem[i]);
`ifdef HSEM_READ_LOCK_EN
                if (w_is_rlr && int'(w_idx) == i)
                    hrdata = r_sem[i].lock ? fmt_entry(r_sem[i]) : fmt_entry(w_rlr_entry);
`endif
            end
            for (int m = 0; m < NUM_MASTER; m++) begin
                if (w_is_bank && int'(w_bank) == m) begin
                    case (w_breg)
                        BANK_IER:  hrdata = 32'(r_ier[m]);
                        BANK_ISR:  hrdata = 32'(r_isr[m]);
                        BANK_MISR: hrdata = 32'(r_isr[m] & r_ier[m]);
                        default:   hrdata = '0;
                    endcase
                end
            end
            if (w_is_keyr)
                hrdata = {r_keyr, 16'h0000};
        end
    end

endmodule

// File: doc/hsem_multi.md
# hsem_multi

Parametrised hardware semaphore for multi-master SoCs. It provides NUM_SEM lock entries behind one AHB-Lite slave port, so several bus masters can arbitrate shared resources. The lock owner is identified by bus master ID (COREID, taken from hmaster) plus a software PROCID. Each master has its own release-interrupt line with enable, status, masked-status and clear registers. Unlock uses ownership checks, and a keyed clear-all releases every lock held by one COREID.

## Interface
- NUM_SEM, 32: number of semaphores, 1..32.
- NUM_MASTER, 2: number of interrupt lines / per-master register banks, 1..4.
- MID_W, 4: hmaster width; COREID = zero-extended hmaster, 8 bits.
- hclk  in  1  the one clock; all state on its rising edge.
- hreset  in  1  reset, synchronous and active-high.
- hsel, hready  in  1  AHB-Lite select / ready-in.
- htrans  in  2  only bit 1 qualifies a transfer.
- hwrite  in  1  direction.
- haddr  in  32  only [9:2] decoded; word accesses only.
- hmaster  in  MID_W  requesting master ID, sampled in address phase.
- hwdata  in  32  write data (data phase).
- hreadyout  out  1  constant 1 (zero wait states).
- hresp  out  2  constant 2'b00 OKAY.
- hrdata  out  32  read data, valid in data phase.
- intr  out  NUM_MASTER  per-master release interrupt, level, active-high.

## Operation
- Address phase: when hsel&hready&htrans[1] is high, register addr[9:2], hwrite, hmaster and valid.
  - Data phase is the next cycle.
  - Register updates occur at the edge ending the data phase.
- Register map (byte offsets):
  - R[i] at 0x000+4i.
  - RLR[i] at 0x080+4i.
  - Per-master m bank at 0x100+0x10m: IER (RW), ICR (W1C, reads 0), ISR (RO), MISR = ISR&IER (RO).
  - CR (WO) at 0x140.
  - KEYR (RW, [31:16]) at 0x144.
  - Unmapped offsets read 0; writes to them are ignored.
- Entry state: LOCK, COREID[7:0], PROCID[7:0]. Read format {LOCK,15'b0,COREID,PROCID}.
- Two-step lock, write R[i] with LOCK=1:
  - If the entry is free, store {1, hmaster, hwdata[7:0]}.
  - If it is already locked, the write is ignored. Software reads back to check ownership.
- Unlock, write R[i] with LOCK=0:
  - Releases the entry only if stored COREID==hmaster and PROCID==hwdata[7:0]; otherwise ignored.
  - Release sets ISR_m[i] for every m < NUM_MASTER.
- Clear-all, write CR {KEY[31:16], COREID[15:8]}:
  - If KEY == KEYR, release every locked entry whose COREID matches. Each released entry sets its ISR bits.
  - Key mismatch: no effect.
- ICR write clears ISR_m bits where hwdata=1. A release set in the same cycle wins over the clear.
- intr[m] = |MISR_m, driven combinationally from registers.
- Bits ≥ NUM_SEM in IER/ISR read 0; R/RLR slots ≥ NUM_SEM read 0.

## Timing
- Reset: all entries free (0), IER/ISR = 0, KEYR = 0, intr = 0, pending address phase dropped.
  - hrdata = 0 during the cycle after reset.
- Reset asserted during a data phase discards the access.
- Write latency: effect visible to a read whose address phase follows the write's data phase. Back-to-back write→read of the same R[i] returns the new value.
- intr[m] rises the cycle after the data-phase edge that sets an enabled ISR bit. It falls the cycle after the ICR write or IER clear.
- Single port: masters are serialized by the bus, so there are no intra-cycle lock races.

## Configuration
- HSEM_READ_LOCK_EN defined: RLR[i] read is a one-step lock.
  - If the entry is free, hrdata = {1,15'b0,hmaster,8'h00}, and the entry locks with PROCID=0 at the end of the data phase.
  - If the entry is locked, hrdata shows the current owner and the state is unchanged.
  - Writes to RLR are ignored.
- HSEM_READ_LOCK_EN undefined: RLR space reads 0 and has no side effects.

## Structure
- Shared package hsem_pkg: register offsets (R_BASE, RLR_BASE, BANK_BASE, CR_OFF, KEYR_OFF), field positions (LOCK_BIT=31, COREID_LSB=8), and the max limits 32 / 4.
- Sub-module hsem_ahb_if: address-phase capture, valid/wr/rd strobes, constant hreadyout/hresp.
- Semaphore array, interrupt banks and read mux stay in the top module.

## Test plan
- Master 1 writes R[3]=0x8000_0005 → read returns 0x8000_0105. Master 2 then writes R[3]=0x8000_0007 → R[3] is still 0x8000_0105.
- Master 2 writes R[3]=0x0000_0005 → ignored. Master 1 writes R[3]=0x0000_0004 → ignored. Master 1 writes R[3]=0x0000_0005 → R[3]=0.
- IER_0=0x8 and R[3] locked, then released → ISR_0=0x8 and intr[0]=1 the next cycle; intr[1]=0 because IER_1=0. ICR_0=0x8 → intr[0]=0.
- KEYR=0x1234, then master 1 locks R[0], R[5] and master 2 locks R[6]:
  - CR=0x5555_0100 → no change.
  - CR=0x1234_0100 → R[0]=R[5]=0 and R[6] unchanged; ISR bits 0 and 5 set.
- With HSEM_READ_LOCK_EN, master 2 reads RLR[9] → 0x8000_0200, and R[9] then reads 0x8000_0200. A second read by master 1 returns 0x8000_0200 with no change. Without the macro, the RLR read returns 0.
- With R[1] locked, assert hreset for one cycle during a write data phase → all R = 0, intr = 0, and the write is lost.
